// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, keeps one fetch outstanding at a time and
// buffers returned words with their PCs for the decoder. A redirect flushes everything.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] INST,
   output logic [31:0] PC,
   output logic        inst_valid,
   input  logic        inst_ready
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      SQUASH = 2'd2
   } state_t;

   state_t        state_r;
   state_t        state_s;
   logic [31:0]   pc_r;
   logic [31:0]   req_pc_r;
   logic [31:0]   fifo_inst_r [DEPTH];
   logic [31:0]   fifo_pc_r   [DEPTH];
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [AW:0]   count_r;
   logic          empty_s;
   logic          push_s;
   logic          pop_s;

   assign empty_s    = (count_r == {(AW+1){1'b0}});
   assign imem_req   = rst_n & ~redirect & (state_r == IDLE) & (count_r < FULL_CNT);
   assign imem_addr  = pc_r;
   // A fetch answered in the redirect cycle belongs to the old stream and is dropped.
   assign push_s     = (state_r == WAIT) & imem_ack & ~redirect;
   assign pop_s      = ~empty_s & inst_ready & ~redirect;
   assign inst_valid = ~empty_s;
   assign INST       = empty_s ? 32'h0000_0000 : fifo_inst_r[rd_ptr_r];
   assign PC         = empty_s ? 32'h0000_0000 : fifo_pc_r[rd_ptr_r];

   // Fetch sequencer next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (imem_req) state_s = WAIT;
            else          state_s = IDLE;
         end
         WAIT: begin
            if (imem_ack)      state_s = IDLE;
            else if (redirect) state_s = SQUASH;
            else               state_s = WAIT;
         end
         SQUASH: begin
            if (imem_ack) state_s = IDLE;
            else          state_s = SQUASH;
         end
         default: state_s = IDLE;
      endcase
   end

   // State, program counter and address of the outstanding fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         pc_r     <= RESET_PC;
         req_pc_r <= 32'h0000_0000;
      end else begin
         state_r <= state_s;
         if (redirect) begin
            pc_r <= {redirect_pc[31:2], 2'b00};
         end else if (imem_req) begin
            pc_r <= pc_r + 32'd4;
         end else begin
            pc_r <= pc_r;
         end
         if (imem_req) req_pc_r <= pc_r;
         else          req_pc_r <= req_pc_r;
      end
   end

   // Buffer storage; written only on an accepted response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_inst_r[i] <= 32'h0000_0000;
            fifo_pc_r[i]   <= 32'h0000_0000;
         end
      end else if (push_s) begin
         fifo_inst_r[wr_ptr_r] <= imem_rdata;
         fifo_pc_r[wr_ptr_r]   <= req_pc_r;
      end
   end

   // Buffer pointers and occupancy; a redirect empties the buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else if (redirect) begin
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         else        wr_ptr_r <= wr_ptr_r;
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         else        rd_ptr_r <= rd_ptr_r;
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: a memory/transaction model predicts fetch
// addresses, buffer occupancy and the delivered instruction stream.
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] MAGIC    = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        imem_ack = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic [31:0] INST;
   logic [31:0] PC;
   logic        inst_valid;
   logic        inst_ready = 1'b0;

   inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_ack(imem_ack),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .INST(INST), .PC(PC), .inst_valid(inst_valid), .inst_ready(inst_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ep;
      logic [31:0] pc;
      logic [31:0] inst;
   } exp_t;

   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_checks = 0;
   int          n_fail = 0;
   int          n_delivered = 0;

   // Transaction-level model state
   int          epoch = 0;
   int          buffered = 0;
   bit          outstanding = 1'b0;
   int          remaining = 0;
   logic [31:0] out_addr = 32'h0;
   logic [31:0] out_exp = 32'h0;
   int          out_epoch = 0;
   bit          stray_pending = 1'b0;
   logic [31:0] exp_fetch = RESET_PC;
   int          lat_lo = 1;
   int          lat_hi = 1;
   bit          last_req = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive just after the rising edge, predict/check at the falling edge.
   task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt, input bit rst);
      bit          ack_now;
      bit          kept;
      bit          exp_req;
      bit          pop;
      int          ack_ep;
      logic [31:0] ack_pc;
      @(posedge clk);
      #1;
      rst_n       = !rst;
      inst_ready  = rdy;
      redirect    = redir && !rst;
      redirect_pc = tgt;
      ack_now     = 1'b0;
      ack_ep      = out_epoch;
      ack_pc      = out_exp;
      if (rst) begin
         if (outstanding) stray_pending = 1'b1;
         outstanding = 1'b0;
         buffered    = 0;
         epoch++;
         exp_fetch   = RESET_PC;
         imem_ack    = 1'b0;
      end else if (stray_pending) begin
         stray_pending = 1'b0;
         imem_ack      = 1'b1;
         imem_rdata    = 32'hDEAD_BEEF;
      end else if (outstanding && remaining == 1) begin
         ack_now     = 1'b1;
         outstanding = 1'b0;
         imem_ack    = 1'b1;
         imem_rdata  = out_addr ^ MAGIC;
      end else begin
         imem_ack = 1'b0;
         if (outstanding) remaining--;
      end
      if (redirect) begin
         epoch++;
         exp_fetch = {tgt[31:2], 2'b00};
      end
      @(negedge clk);
      chk("inst_valid", 32'(inst_valid), 32'(buffered != 0));
      exp_req = rst_n && !redirect && !outstanding && !ack_now && (buffered < DEPTH);
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (!rst_n) chk("reset_addr", imem_addr, RESET_PC);
      if (imem_req && exp_req) begin
         chk("imem_addr", imem_addr, exp_fetch);
         outstanding = 1'b1;
         remaining   = $urandom_range(lat_hi, lat_lo);
         out_addr    = imem_addr;
         out_exp     = exp_fetch;
         out_epoch   = epoch;
         exp_fetch   = exp_fetch + 32'd4;
      end
      last_req = imem_req;
      kept = ack_now && (ack_ep == epoch) && !redirect;
      pop  = (buffered != 0) && rdy && !redirect;
      if (kept) begin
         sb_q.push_back('{ep: epoch, pc: ack_pc, inst: ack_pc ^ MAGIC});
         buffered++;
      end
      if (pop) buffered--;
      if (redirect || !rst_n) buffered = 0;
   endtask

   // Monitor: compare every delivered entry against the scoreboard.
   always @(negedge clk) begin
      if (inst_valid && inst_ready && !redirect && rst_n) begin
         while (sb_q.size() > 0 && sb_q[0].ep != epoch) void'(sb_q.pop_front());
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got PC %h with no entry expected", PC);
         end else begin
            mon_e = sb_q.pop_front();
            chk("deliver_pc", PC, mon_e.pc);
            chk("deliver_inst", INST, mon_e.inst);
            n_delivered++;
         end
      end else if (!inst_valid) begin
         chk("idle_inst", INST, 32'h0);
         chk("idle_pc", PC, 32'h0);
      end
   end

   initial begin
      bit found;
      // Reset, then free run with single-cycle memory
      repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
      lat_lo = 1; lat_hi = 1;
      repeat (20) step(1'b1, 1'b0, 32'h0, 1'b0);
      // Decoder stall fills the buffer, then drains in order
      repeat (12) step(1'b0, 1'b0, 32'h0, 1'b0);
      repeat (10) step(1'b1, 1'b0, 32'h0, 1'b0);
      // 3-cycle memory, redirect in the cycle after a request
      lat_lo = 3; lat_hi = 3;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b1, 1'b0, 32'h0, 1'b0);
         found = last_req;
      end
      chk("wait_req", 32'(found), 32'd1);
      step(1'b1, 1'b1, 32'h0000_0103, 1'b0);
      repeat (16) step(1'b1, 1'b0, 32'h0, 1'b0);
      // Redirect coinciding with an ack
      lat_lo = 2; lat_hi = 2;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (outstanding && remaining == 1) found = 1'b1;
         else step(1'b1, 1'b0, 32'h0, 1'b0);
      end
      chk("wait_ack", 32'(found), 32'd1);
      step(1'b1, 1'b1, 32'h0000_0200, 1'b0);
      repeat (12) step(1'b1, 1'b0, 32'h0, 1'b0);
      // Address wrap past the top of memory
      lat_lo = 1; lat_hi = 1;
      step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
      repeat (14) step(1'b1, 1'b0, 32'h0, 1'b0);
      // Random latency, ready and redirects
      lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 400; i++)
         step($urandom_range(3, 0) != 0, $urandom_range(29, 0) == 0, $urandom, 1'b0);
      // Reset while a fetch is outstanding with data buffered; stray ack after release
      lat_lo = 3; lat_hi = 3;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (outstanding && buffered >= 1) found = 1'b1;
         else step(1'b0, 1'b0, 32'h0, 1'b0);
      end
      chk("wait_wait_state", 32'(found), 32'd1);
      repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1);
      lat_lo = 1; lat_hi = 1;
      repeat (20) step(1'b1, 1'b0, 32'h0, 1'b0);
      chk("delivered_min", 32'(n_delivered > 50), 32'd1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
